pipe_stage_chain: RTL and testbench

- Parametrised successor to the fixed inter-stage pipeline latch bundles: a generic WIDTH-bit payload register chain of DEPTH stages, with per-entry valid bit.
- Adds stall (en), flush (bubble insertion), a sticky halt, register-write gating and occupancy reporting.
- Sits between any two datapath stages (IF/ID through MEM/WB) or models multi-cycle units; the payload is the packed stage bundle (npc, ALUOut, load, rd, etc.).

---
 rtl/pipe_stage_chain.sv | 136 +++++++++++++
 tb/tb_pipe_stage_chain.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: generic DEPTH-stage WIDTH-bit pipeline latch chain with
// per-entry valid, register-write and halt bits, plus stall, flush, sticky
// halt and occupancy reporting.
// Build option: define PIPE_COLLAPSE_EN to let earlier stages squeeze out
// bubbles while the output is stalled; leave it undefined for a lockstep
// chain where every stage moves only on en.
module pipe_stage_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_wen,
    input  logic             in_halt,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_wen,
    output logic             out_halt,
    output logic [OCC_W-1:0] occupancy
);

    // Per-stage state; index 0 is the input side, DEPTH-1 the output side.
    logic             r_valid [DEPTH];
    logic             r_wen   [DEPTH];
    logic             r_halt  [DEPTH];
    logic [WIDTH-1:0] r_data  [DEPTH];
    logic             r_out_halt;

    // Per-stage advance strobes and the value each stage would load.
    logic [DEPTH-1:0] w_adv;
    logic             w_src_valid [DEPTH];
    logic             w_src_wen   [DEPTH];
    logic             w_src_halt  [DEPTH];
    logic [WIDTH-1:0] w_src_data  [DEPTH];
    logic             w_take;
    logic [OCC_W-1:0] w_occ;

    genvar gi;

`ifdef PIPE_COLLAPSE_EN
    // A stage may load when it is empty or when its own entry is moving on
    // this edge, so an empty slot pulls older entries forward even while
    // the output is stalled. The output stage moves on en or when empty.
    assign w_adv[DEPTH-1] = en | ~r_valid[DEPTH-1];
    generate
        for (gi = 0; gi < DEPTH - 1; gi++) begin : g_adv
            assign w_adv[gi] = w_adv[gi+1] | ~r_valid[gi];
        end
    endgenerate
`else
    // Lockstep: every stage moves together on en, bubbles included.
    assign w_adv = {DEPTH{en}};
`endif

    // Input accepted only when stage 0 moves and no halt has retired yet.
    assign in_ready = w_adv[0] & ~r_out_halt;
    assign w_take   = in_valid & in_ready;

    // Source selection: stage 0 loads the upstream entry (or a bubble),
    // every later stage loads its predecessor.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_src
            if (gi == 0) begin : g_first
                assign w_src_valid[gi] = w_take;
                assign w_src_wen[gi]   = in_wen & w_take;
                assign w_src_halt[gi]  = in_halt & w_take;
                assign w_src_data[gi]  = in_data;
            end else begin : g_rest
                assign w_src_valid[gi] = r_valid[gi-1];
                assign w_src_wen[gi]   = r_wen[gi-1];
                assign w_src_halt[gi]  = r_halt[gi-1];
                assign w_src_data[gi]  = r_data[gi-1];
            end
        end
    endgenerate

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            // Stage register: reset clears everything, flush drops the
            // control bits (payload may still shift), otherwise load on adv.
            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    r_valid[gi] <= 1'b0;
                    r_wen[gi]   <= 1'b0;
                    r_halt[gi]  <= 1'b0;
                    r_data[gi]  <= '0;
                end else begin
                    if (w_adv[gi]) begin
                        r_data[gi] <= w_src_data[gi];
                    end
                    if (flush) begin
                        r_valid[gi] <= 1'b0;
                        r_wen[gi]   <= 1'b0;
                        r_halt[gi]  <= 1'b0;
                    end else if (w_adv[gi]) begin
                        r_valid[gi] <= w_src_valid[gi];
                        r_wen[gi]   <= w_src_wen[gi];
                        r_halt[gi]  <= w_src_halt[gi];
                    end
                end
            end
        end
    endgenerate

    // Sticky halt: latches when a valid halt entry leaves the output stage;
    // only reset clears it (flush does not).
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_out_halt <= 1'b0;
        end else if (r_valid[DEPTH-1] & r_halt[DEPTH-1] & en) begin
            r_out_halt <= 1'b1;
        end
    end

    // Occupancy is a plain popcount of the valid bits.
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(r_valid[i]);
        end
    end

    assign occupancy = w_occ;
    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];
    // Valid-gated so a bubble never writes the register file.
    assign out_wen   = r_wen[DEPTH-1] & r_valid[DEPTH-1];
    assign out_halt  = r_out_halt;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: cycle table of inputs and expected control outputs
// for a DEPTH=3 chain, with a payload scoreboard checking output order.
// Honours PIPE_COLLAPSE_EN to pick the matching expectations.
module tb_pipe_stage_chain;

    localparam int WIDTH = 32;
    localparam int DEPTH = 3;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             CLK = 1'b0;
    logic             nRST = 1'b0;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_wen = 1'b0;
    logic             in_halt = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_wen;
    logic             out_halt;
    logic [OCC_W-1:0] occupancy;

    pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_wen    (in_wen),
        .in_halt   (in_halt),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_wen   (out_wen),
        .out_halt  (out_halt),
        .occupancy (occupancy)
    );

    always #5 CLK = ~CLK;

    // One row per clock cycle: inputs held for the cycle, and the outputs
    // expected just before that cycle's rising edge.
    typedef struct {
        logic        nrst;
        logic        en;
        logic        fl;
        logic        iv;
        logic [31:0] id;
        logic        iw;
        logic        ih;
        logic        chk;
        logic        er;
        logic        ev;
        logic        ew;
        logic        eh;
        logic [1:0]  eo;
        logic        dz;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic add(input logic nrst, input logic en_i, input logic fl,
                       input logic iv, input logic [31:0] id, input logic iw,
                       input logic ih, input logic chk, input logic er,
                       input logic ev, input logic ew, input logic eh,
                       input logic [1:0] eo, input logic dz);
        vec_t v;
        v.nrst = nrst; v.en = en_i; v.fl = fl; v.iv = iv; v.id = id;
        v.iw = iw; v.ih = ih; v.chk = chk; v.er = er; v.ev = ev;
        v.ew = ew; v.eh = eh; v.eo = eo; v.dz = dz;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, row, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        //   nrst en fl iv data     iw ih | chk rdy vld wen hlt occ dz
        // reset, then latency: A, B, C out on consecutive cycles
        add(0, 1, 0, 0, 32'h0,    0, 0,   0,  0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 32'hA,    1, 0,   1,  1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 32'hB,    1, 0,   1,  1, 0, 0, 0, 1, 0);
        add(1, 1, 0, 1, 32'hC,    1, 0,   1,  1, 0, 0, 0, 2, 0);
        add(1, 1, 0, 0, 32'h0,    0, 0,   1,  1, 1, 1, 0, 3, 0);
        add(1, 1, 0, 0, 32'h0,    0, 0,   1,  1, 1, 1, 0, 2, 0);
        add(1, 1, 0, 0, 32'h0,    0, 0,   1,  1, 1, 1, 0, 1, 0);
        // push 1, idle, push 2, then stall
        add(1, 1, 0, 1, 32'h1,    0, 0,   1,  1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 32'h0,    0, 0,   1,  1, 0, 0, 0, 1, 0);
        add(1, 1, 0, 1, 32'h2,    0, 0,   1,  1, 0, 0, 0, 1, 0);
`ifdef PIPE_COLLAPSE_EN
        add(1, 0, 0, 0, 32'h0,    0, 0,   1,  1, 1, 0, 0, 2, 0);
        add(1, 0, 0, 1, 32'h3,    0, 0,   1,  1, 1, 0, 0, 2, 0);
        add(1, 0, 0, 0, 32'h0,    0, 0,   1,  0, 1, 0, 0, 3, 0);
        add(1, 1, 0, 0, 32'h0,    0, 0,   1,  1, 1, 0, 0, 3, 0);
        add(1, 1, 0, 0, 32'h0,    0, 0,   1,  1, 1, 0, 0, 2, 0);
        add(1, 1, 0, 0, 32'h0,    0, 0,   1,  1, 1, 0, 0, 1, 0);
        add(1, 1, 0, 0, 32'h0,    0, 0,   1,  1, 0, 0, 0, 0, 0);
`else
        add(1, 0, 0, 0, 32'h0,    0, 0,   1,  0, 1, 0, 0, 2, 0);
        add(1, 0, 0, 1, 32'h3,    0, 0,   1,  0, 1, 0, 0, 2, 0);
        add(1, 0, 0, 0, 32'h0,    0, 0,   1,  0, 1, 0, 0, 2, 0);
        add(1, 1, 0, 1, 32'h3,    0, 0,   1,  1, 1, 0, 0, 2, 0);
        add(1, 1, 0, 0, 32'h0,    0, 0,   1,  1, 0, 0, 0, 2, 0);
        add(1, 1, 0, 0, 32'h0,    0, 0,   1,  1, 1, 0, 0, 2, 0);
        add(1, 1, 0, 0, 32'h0,    0, 0,   1,  1, 1, 0, 0, 1, 0);
`endif
        // fill with wen=1, then flush together with a new input 0xF
        add(1, 1, 0, 1, 32'h11,   1, 0,   1,  1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 32'h12,   1, 0,   1,  1, 0, 0, 0, 1, 0);
        add(1, 1, 0, 1, 32'h13,   1, 0,   1,  1, 0, 0, 0, 2, 0);
        add(1, 1, 1, 1, 32'hF,    1, 0,   1,  1, 1, 1, 0, 3, 0);
        add(1, 1, 0, 0, 32'h0,    0, 0,   1,  1, 0, 0, 0, 0, 0);
        // halt entry 5 followed by 6; later pushes refused, flush keeps halt
        add(1, 1, 0, 1, 32'h5,    0, 1,   1,  1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 32'h6,    0, 0,   1,  1, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0, 32'h0,    0, 0,   1,  1, 0, 0, 0, 2, 0);
        add(1, 1, 0, 0, 32'h0,    0, 0,   1,  1, 1, 0, 0, 2, 0);
        add(1, 1, 0, 1, 32'h7,    0, 0,   1,  0, 1, 0, 1, 1, 0);
        add(1, 1, 0, 1, 32'h8,    0, 0,   1,  0, 0, 0, 1, 0, 0);
        add(1, 1, 1, 0, 32'h0,    0, 0,   1,  0, 0, 0, 1, 0, 0);
        add(1, 1, 0, 1, 32'h9,    0, 0,   1,  0, 0, 0, 1, 0, 0);
        // reset clears halt; then fill, stall full, reset mid-stall
        add(0, 1, 0, 0, 32'h0,    0, 0,   1,  0, 0, 0, 1, 0, 0);
        add(1, 1, 0, 1, 32'h21,   1, 0,   1,  1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 32'h22,   1, 0,   1,  1, 0, 0, 0, 1, 0);
        add(1, 1, 0, 1, 32'h23,   1, 0,   1,  1, 0, 0, 0, 2, 0);
        add(1, 0, 0, 1, 32'h24,   1, 0,   1,  0, 1, 1, 0, 3, 0);
        add(0, 0, 0, 1, 32'h25,   1, 1,   1,  0, 1, 1, 0, 3, 0);
        add(1, 1, 0, 0, 32'h0,    0, 0,   1,  1, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 32'h0,    0, 0,   1,  1, 0, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge CLK);
            nRST     = v.nrst;
            en       = v.en;
            flush    = v.fl;
            in_valid = v.iv;
            in_data  = v.id;
            in_wen   = v.iw;
            in_halt  = v.ih;
            #1;
            if (v.chk) begin
                check("in_ready",  i, 32'(in_ready),  32'(v.er));
                check("out_valid", i, 32'(out_valid), 32'(v.ev));
                check("out_wen",   i, 32'(out_wen),   32'(v.ew));
                check("out_halt",  i, 32'(out_halt),  32'(v.eh));
                check("occupancy", i, 32'(occupancy), 32'(v.eo));
            end
            if (v.dz) begin
                check("data_zero", i, out_data, 32'h0);
            end
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL scoreboard row %0d: got unexpected entry 0x%0h, expected none", i, out_data);
                end else begin
                    check("out_data", i, out_data, sb[0]);
                end
            end
            $display("row %0d: nRST=%0b en=%0b flush=%0b in=%0b/0x%0h ready=%0b out=%0b/0x%0h wen=%0b halt=%0b occ=%0d",
                     i, v.nrst, v.en, v.fl, v.iv, v.id, in_ready, out_valid, out_data,
                     out_wen, out_halt, occupancy);
            // Update the scoreboard for what the coming edge should do.
            if (!v.nrst || v.fl) begin
                sb.delete();
            end else begin
                if (v.ev && v.en && sb.size() > 0) begin
                    void'(sb.pop_front());
                end
                if (v.iv && v.er) begin
                    sb.push_back(v.id);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
